dmem_hs: RTL and testbench

DMEM_HS -- requirements
Module: dmem_hs

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_hs_if.sv | 29 ++
 rtl/dmem_ram.sv | 28 ++
 rtl/dmem_hs.sv | 135 +++++++++++++
 tb/tb_dmem_hs.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the handshaked data memory: access types and FSM states.
package dmem_pkg;

   localparam logic [2:0] TYPE_B  = 3'b000;
   localparam logic [2:0] TYPE_H  = 3'b001;
   localparam logic [2:0] TYPE_W  = 3'b010;
   localparam logic [2:0] TYPE_BU = 3'b100;
   localparam logic [2:0] TYPE_HU = 3'b101;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

endpackage

// File: rtl/dmem_hs_if.sv
// Request/response bus of the data memory; the requester is the master.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the source holds its payload stable while valid=1 and ready=0.
interface dmem_hs_if;
   import dmem_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_type;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [15:0] err_cnt;

   modport master (
      output req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt
   );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
module dmem_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_hs.sv
// Handshaked data memory: one outstanding request, fault checking, byte lanes,
// load extension and a saturating fault counter around a dmem_ram.
module dmem_hs
   import dmem_pkg::*;
#(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst,
   dmem_hs_if.slave   bus,
   output state_e     o_dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] L_IDLE = ST_IDLE;
   localparam logic [0:0] L_RESP = ST_RESP;

   logic [0:0]  r_state;
   logic        r_err;
   logic        r_load;
   logic [2:0]  r_type;
   logic [1:0]  r_lane;
   logic [15:0] r_err_cnt;

   logic        w_accept;
   logic        w_legal;
   logic        w_align_ok;
   logic        w_range_ok;
   logic        w_fault;
   logic [3:0]  w_be;
   logic [31:0] w_wdata_rep;
   logic        w_ram_en;
   logic [3:0]  w_ram_we;
   logic [31:0] w_ram_rdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;

   // Held low during reset so a request presented with rst=1 is never taken.
   assign bus.req_ready = (r_state == L_IDLE) && !rst;
   assign w_accept      = bus.req_valid && bus.req_ready;

   always_comb begin
      w_legal     = 1'b1;
      w_align_ok  = 1'b1;
      w_be        = 4'b0000;
      w_wdata_rep = bus.req_wdata;
      case (bus.req_type)
         TYPE_B, TYPE_BU: begin
            w_be        = 4'b0001 << bus.req_addr[1:0];
            w_wdata_rep = {4{bus.req_wdata[7:0]}};
         end
         TYPE_H, TYPE_HU: begin
            w_align_ok  = !bus.req_addr[0];
            w_be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_rep = {2{bus.req_wdata[15:0]}};
         end
         TYPE_W: begin
            w_align_ok  = (bus.req_addr[1:0] == 2'b00);
            w_be        = 4'b1111;
         end
         default: w_legal = 1'b0;
      endcase
   end

   // BASE_ADDR is DEPTH*4 aligned, so the window test reduces to matching upper bits
   // and the word index is simply the address bits just above the byte lane.
   assign w_range_ok = (bus.req_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
   assign w_fault    = !w_legal || !w_align_ok || !w_range_ok;
   assign w_ram_en   = w_accept && !w_fault;
   assign w_ram_we   = (w_ram_en && bus.req_we) ? w_be : 4'b0000;

   dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (bus.req_addr[AW+1:2]),
      .i_wdata (w_wdata_rep),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= L_IDLE;
         r_err     <= 1'b0;
         r_load    <= 1'b0;
         r_type    <= TYPE_W;
         r_lane    <= 2'b00;
         r_err_cnt <= 16'h0000;
      end else begin
         case (r_state)
            L_IDLE: begin
               if (w_accept) begin
                  r_state <= L_RESP;
                  r_err   <= w_fault;
                  r_load  <= !bus.req_we && !w_fault;
                  r_type  <= bus.req_type;
                  r_lane  <= bus.req_addr[1:0];
                  if (w_fault && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
               end
            end
            default: begin
               if (bus.rsp_ready) r_state <= L_IDLE;
            end
         endcase
      end
   end

   // The RAM output only changes on an accept, so the response is stable while stalled.
   always_comb begin
      case (r_lane)
         2'd0:    w_byte = w_ram_rdata[7:0];
         2'd1:    w_byte = w_ram_rdata[15:8];
         2'd2:    w_byte = w_ram_rdata[23:16];
         default: w_byte = w_ram_rdata[31:24];
      endcase
      w_half = r_lane[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];
      case (r_type)
         TYPE_B:  w_ext = {{24{w_byte[7]}}, w_byte};
         TYPE_BU: w_ext = {24'h0, w_byte};
         TYPE_H:  w_ext = {{16{w_half[15]}}, w_half};
         TYPE_HU: w_ext = {16'h0, w_half};
         TYPE_W:  w_ext = w_ram_rdata;
         default: w_ext = 32'h0;
      endcase
   end

   assign bus.rsp_valid = (r_state == L_RESP);
   assign bus.rsp_err   = (r_state == L_RESP) && r_err;
   assign bus.rsp_rdata = ((r_state == L_RESP) && r_load) ? w_ext : 32'h0;
   assign bus.err_cnt   = r_err_cnt;
   assign o_dbg_state   = state_e'(r_state);

endmodule

// File: tb/tb_dmem_hs.sv
// Randomized bench for dmem_hs: byte-array reference model, expected-response queue
// and an independent monitor that checks every response handshake.
module tb_dmem_hs;
   import dmem_pkg::*;

   localparam int          DEPTH     = 256;
   localparam logic [31:0] BASE      = 32'h0000_0000;
   localparam logic [31:0] MEM_BYTES = DEPTH * 4;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_e dbg_state;

   dmem_hs_if bus ();

   dmem_hs #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // {err_cnt, err, rdata}
   logic [48:0] exp_q[$];

   logic [7:0] mem_m [DEPTH*4];
   int         m_err_cnt = 0;
   bit         rr_force  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: an access is a little-endian group of n bytes at a byte offset.
   task automatic model(input bit we, input logic [31:0] addr, input logic [2:0] typ,
                        input logic [31:0] wd, output logic [31:0] rd, output bit err);
      int     n;
      bit     sgn;
      longint off;
      n = 0;
      sgn = 1'b0;
      case (typ)
         3'd0: begin n = 1; sgn = 1'b1; end
         3'd1: begin n = 2; sgn = 1'b1; end
         3'd2: n = 4;
         3'd4: n = 1;
         3'd5: n = 2;
         default: n = 0;
      endcase
      off = longint'(addr) - longint'(BASE);
      err = (n == 0) || ((int'(addr[1:0]) % n) != 0) || (off < 0) || (off >= longint'(MEM_BYTES));
      rd = 32'h0;
      if (err) begin
         if (m_err_cnt < 65535) m_err_cnt++;
         return;
      end
      if (we) begin
         for (int i = 0; i < n; i++) mem_m[int'(off) + i] = wd[8*i +: 8];
      end else begin
         for (int i = 0; i < n; i++) rd[8*i +: 8] = mem_m[int'(off) + i];
         if (sgn && rd[8*n-1]) begin
            for (int i = 8*n; i < 32; i++) rd[i] = 1'b1;
         end
      end
   endtask

   task automatic issue(input bit we, input logic [31:0] addr, input logic [2:0] typ,
                        input logic [31:0] wd, input bit use_k, input logic [31:0] k);
      logic [31:0] rd;
      bit          er;
      int          n;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_type  = typ;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      n = 0;
      #1;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (!bus.req_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      model(we, addr, typ, wd, rd, er);
      exp_q.push_back({m_err_cnt[15:0], er, (use_k ? k : rd)});
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      chk("latency_valid", 32'(bus.rsp_valid), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !bus.req_ready) && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   // Response acceptance: random backpressure unless a directed test owns rsp_ready.
   initial begin
      forever begin
         @(negedge clk);
         if (!rr_force) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: a response is consumed on the next rising edge when valid and ready are both high.
   initial begin
      logic [48:0] e;
      forever begin
         @(negedge clk); #1;
         if (bus.rsp_valid && bus.rsp_ready && !rst) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", bus.rsp_rdata, e[31:0]);
               chk("rsp_err", 32'(bus.rsp_err), 32'(e[32]));
               chk("err_cnt", 32'(bus.err_cnt), 32'(e[48:33]));
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_word;
      logic [31:0] addr;
      logic [2:0]  typ;
      bit          we;
      int          t;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_type  = TYPE_W;
      bus.req_wdata = 32'h0;
      bus.rsp_ready = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("reset_err_cnt", 32'(bus.err_cnt), 32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

      for (int w = 0; w < DEPTH; w++) issue(1'b1, 32'(w * 4), TYPE_W, $urandom(), 1'b0, 32'h0);

      issue(1'b1, 32'h10, TYPE_W, 32'hDEADBEEF, 1'b0, 32'h0);
      issue(1'b0, 32'h10, TYPE_W, 32'h0, 1'b1, 32'hDEADBEEF);
      issue(1'b1, 32'h13, TYPE_B, 32'h0000007F, 1'b0, 32'h0);
      issue(1'b0, 32'h13, TYPE_B, 32'h0, 1'b1, 32'h0000007F);
      issue(1'b0, 32'h11, TYPE_BU, 32'h0, 1'b1, 32'h000000BE);
      issue(1'b0, 32'h11, TYPE_B, 32'h0, 1'b1, 32'hFFFFFFBE);
      issue(1'b0, 32'h12, TYPE_H, 32'h0, 1'b1, 32'h00007FAD);

      issue(1'b0, 32'h12, TYPE_W, 32'h0, 1'b1, 32'h0);
      issue(1'b1, 32'h11, TYPE_H, 32'h0000FFFF, 1'b1, 32'h0);
      issue(1'b0, 32'h10, 3'b011, 32'h0, 1'b1, 32'h0);
      issue(1'b0, MEM_BYTES, TYPE_W, 32'h0, 1'b1, 32'h0);
      drain();
      chk("err_cnt_four", 32'(bus.err_cnt), 32'd4);
      issue(1'b0, 32'h10, TYPE_W, 32'h0, 1'b1, 32'h7FADBEEF);

      // Stalled response with a second request waiting that must be ignored.
      drain();
      @(negedge clk);
      rr_force = 1'b1;
      bus.rsp_ready = 1'b0;
      issue(1'b0, 32'h10, TYPE_W, 32'h0, 1'b1, 32'h7FADBEEF);
      exp_word = 32'h7FADBEEF;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_type  = TYPE_W;
      bus.req_wdata = 32'hA5A55A5A;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_rsp_rdata", bus.rsp_rdata, exp_word);
         chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk); #1;
      chk("hold_back_idle", 32'(dbg_state), 32'(ST_IDLE));
      chk("hold_ready_again", 32'(bus.req_ready), 32'd1);
      rr_force = 1'b0;
      issue(1'b0, 32'h20, TYPE_W, 32'h0, 1'b0, 32'h0);

      // Reset in RESP drops the response; a store presented during reset must not land.
      drain();
      @(negedge clk);
      rr_force = 1'b1;
      bus.rsp_ready = 1'b0;
      issue(1'b0, 32'h14, TYPE_W, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h10;
      bus.req_type  = TYPE_W;
      bus.req_wdata = 32'h12345678;
      bus.req_valid = 1'b1;
      @(negedge clk); #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      chk("rst_ready_after", 32'(bus.req_ready), 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      m_err_cnt = 0;
      rr_force = 1'b0;
      issue(1'b0, 32'h10, TYPE_W, 32'h0, 1'b1, 32'h7FADBEEF);
      issue(1'b0, 32'h14, TYPE_W, 32'h0, 1'b0, 32'h0);

      for (int k = 0; k < 400; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 99) < 6) begin
            t = $urandom_range(0, 2);
            typ = (t == 0) ? 3'b011 : ((t == 1) ? 3'b110 : 3'b111);
            we = 1'($urandom_range(0, 1));
         end else begin
            we = 1'($urandom_range(0, 1));
            if (we) begin
               typ = 3'($urandom_range(0, 2));
            end else begin
               t = $urandom_range(0, 4);
               typ = (t < 3) ? 3'(t) : 3'(t + 1);
            end
         end
         addr = 32'($urandom_range(0, DEPTH * 4 - 1));
         if ($urandom_range(0, 19) == 0) addr = MEM_BYTES + 32'($urandom_range(0, 1023) * 4);
         if ($urandom_range(0, 39) == 0) addr = 32'hFFFF_FFF0;
         if ($urandom_range(0, 9) != 0) begin
            if (typ == TYPE_H || typ == TYPE_HU) addr[0] = 1'b0;
            if (typ == TYPE_W) addr[1:0] = 2'b00;
         end
         issue(we, addr, typ, $urandom(), 1'b0, 32'h0);
      end

      drain();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
